// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire bit-level master: command codes, FSM
// states and slot timing in microseconds.
package onewire_pkg;

  // Command encodings on the cmd port; 2'b11 is reserved and ignored.
  localparam logic [1:0] CMD_RESET = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RST_LOW,
    RST_WAIT,
    WR_LOW,
    RD_LOW,
    RD_WAIT,
    RECOVER
  } state_t;

  // Slot timing, microseconds measured from command acceptance.
  localparam int unsigned T_RST_LOW_US   = 480;  // reset pulse length
  localparam int unsigned T_PRESENCE_US  = 550;  // presence sample point
  localparam int unsigned T_RST_SLOT_US  = 960;  // end of reset/presence slot
  localparam int unsigned T_SHORT_LOW_US = 6;    // write-1 and read low time
  localparam int unsigned T_WR0_LOW_US   = 60;   // write-0 low time
  localparam int unsigned T_RD_SAMPLE_US = 15;   // read sample point
  localparam int unsigned T_SLOT_US      = 70;   // end of write/read slot

endpackage

// File: rtl/onewire_pad_sync.sv
// Line capture for the 1-Wire pad return.
// ONEWIRE_INPUT_SYNC_EN defined: two-flop synchroniser on the pad input.
// ONEWIRE_INPUT_SYNC_EN undefined: a single capture flop.
module onewire_pad_sync (
  input  logic clk,
  input  logic reset,
  input  logic pad_i,
  output logic line_sample
);

`ifdef ONEWIRE_INPUT_SYNC_EN
  logic meta_q;

  // Two-stage synchroniser; flops reset to the idle (pulled-up) level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q      <= 1'b1;
      line_sample <= 1'b1;
    end else begin
      meta_q      <= pad_i;
      line_sample <= meta_q;
    end
  end
`else
  // Single capture flop; resets to the idle (pulled-up) level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_sample <= 1'b1;
    end else begin
      line_sample <= pad_i;
    end
  end
`endif

endmodule

// File: rtl/onewire_master.sv
// Bit-level 1-Wire bus master. One primitive per command: reset/presence,
// write bit, read bit. Drives an open-drain pad via pad_t (pad_o tied low).
// Input capture depth selected by ONEWIRE_INPUT_SYNC_EN (see onewire_pad_sync).
module onewire_master
  import onewire_pkg::*;
#(
  parameter int unsigned CLK_PER_US = 50,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] cmd,
  input  logic       cmd_strobe,
  input  logic       tx_bit,
  output logic       busy,
  output logic       done,
  output logic       rx_bit,
  output logic       presence,
  output logic       pad_o,
  output logic       pad_t,
  input  logic       pad_i
);

  // Phase boundaries in clock cycles after acceptance.
  localparam logic [CNT_W-1:0] C_RST_LOW   = CNT_W'(T_RST_LOW_US * CLK_PER_US);
  localparam logic [CNT_W-1:0] C_PRESENCE  = CNT_W'(T_PRESENCE_US * CLK_PER_US);
  localparam logic [CNT_W-1:0] C_RST_SLOT  = CNT_W'(T_RST_SLOT_US * CLK_PER_US);
  localparam logic [CNT_W-1:0] C_SHORT_LOW = CNT_W'(T_SHORT_LOW_US * CLK_PER_US);
  localparam logic [CNT_W-1:0] C_WR0_LOW   = CNT_W'(T_WR0_LOW_US * CLK_PER_US);
  localparam logic [CNT_W-1:0] C_RD_SAMPLE = CNT_W'(T_RD_SAMPLE_US * CLK_PER_US);
  localparam logic [CNT_W-1:0] C_SLOT      = CNT_W'(T_SLOT_US * CLK_PER_US);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             tx_q;
  logic             line_sample;
  logic [CNT_W-1:0] wr_low_end;

  // The line is only ever pulled low or released, never driven high.
  assign pad_o = 1'b0;

  // Boundaries compare against the incremented count so that count value k
  // is reached exactly k cycles after the accepting edge.
  assign cnt_inc    = cnt + 1'b1;
  assign wr_low_end = tx_q ? C_SHORT_LOW : C_WR0_LOW;

  onewire_pad_sync u_pad_sync (
    .clk         (clk),
    .reset       (reset),
    .pad_i       (pad_i),
    .line_sample (line_sample)
  );

  // Command FSM with slot counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      tx_q     <= 1'b0;
      pad_t    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_bit   <= 1'b0;
      presence <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (cmd_strobe && (cmd != 2'b11)) begin
            busy  <= 1'b1;
            pad_t <= 1'b0;
            tx_q  <= tx_bit;
            if (cmd == CMD_RESET) begin
              state <= RST_LOW;
            end else if (cmd == CMD_WRITE) begin
              state <= WR_LOW;
            end else begin
              state <= RD_LOW;
            end
          end
        end

        RST_LOW: begin
          cnt <= cnt_inc;
          if (cnt_inc == C_RST_LOW) begin
            pad_t <= 1'b1;
            state <= RST_WAIT;
          end
        end

        RST_WAIT: begin
          cnt <= cnt_inc;
          if (cnt_inc == C_PRESENCE) begin
            presence <= ~line_sample;
          end
          if (cnt_inc == C_RST_SLOT) begin
            cnt   <= '0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        WR_LOW: begin
          cnt <= cnt_inc;
          if (cnt_inc == wr_low_end) begin
            pad_t <= 1'b1;
            state <= RECOVER;
          end
        end

        RD_LOW: begin
          cnt <= cnt_inc;
          if (cnt_inc == C_SHORT_LOW) begin
            pad_t <= 1'b1;
            state <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          cnt <= cnt_inc;
          if (cnt_inc == C_RD_SAMPLE) begin
            rx_bit <= line_sample;
            state  <= RECOVER;
          end
        end

        RECOVER: begin
          cnt <= cnt_inc;
          if (cnt_inc == C_SLOT) begin
            cnt   <= '0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          cnt   <= '0;
          pad_t <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onewire_master.sv
// Scoreboard bench for onewire_master at CLK_PER_US=2. Stimulus pushes the
// expected slot shape per command; the monitor measures each command from the
// busy rising edge to the done pulse and compares.
module tb_onewire_master;
  import onewire_pkg::*;

  localparam int unsigned CPU = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] cmd;
  logic       cmd_strobe;
  logic       tx_bit;
  logic       busy;
  logic       done;
  logic       rx_bit;
  logic       presence;
  logic       pad_o;
  logic       pad_t;
  logic       pad_i;

  onewire_master #(
    .CLK_PER_US (CPU),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd),
    .cmd_strobe (cmd_strobe),
    .tx_bit     (tx_bit),
    .busy       (busy),
    .done       (done),
    .rx_bit     (rx_bit),
    .presence   (presence),
    .pad_o      (pad_o),
    .pad_t      (pad_t),
    .pad_i      (pad_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Device model: pulls the line low while lo <= rel < hi, rel = cycles after
  // the accepting edge of the current command.
  int   acc_cyc = 0;
  int   dev_lo  = 0;
  int   dev_hi  = 0;
  int   rel;
  logic dev_low;
  assign rel     = cyc - acc_cyc;
  assign dev_low = (rel >= dev_lo) && (rel < dev_hi);
  assign pad_i   = pad_t ? ~dev_low : pad_o;

  typedef struct {
    string name;
    int    dur;   // cycles from acceptance to done
    int    low;   // cycles with pad_t low
    int    kind;  // 0 none, 1 presence, 2 rx_bit
    int    val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: sample #1 after each edge, measure and score each command.
  logic tracking  = 1'b0;
  logic busy_prev = 1'b0;
  int   mon_acc   = 0;
  int   low_cnt   = 0;

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        check({e.name, "_dur"}, cyc - mon_acc, e.dur);
        check({e.name, "_low"}, low_cnt, e.low);
        check({e.name, "_busy_at_done"}, int'(busy), 0);
        check({e.name, "_pad_o"}, int'(pad_o), 0);
        if (e.kind == 1) check({e.name, "_presence"}, int'(presence), e.val);
        if (e.kind == 2) check({e.name, "_rx_bit"}, int'(rx_bit), e.val);
      end
      tracking = 1'b0;
    end else if (busy && !busy_prev) begin
      tracking = 1'b1;
      mon_acc  = cyc;
      low_cnt  = 0;
    end else if (!busy) begin
      tracking = 1'b0;
    end
    if (tracking && !pad_t) low_cnt++;
    busy_prev = busy;
  end

  task automatic issue(input logic [1:0] c, input logic b);
    @(negedge clk);
    cmd        = c;
    tx_bit     = b;
    cmd_strobe = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc    = cyc;
    cmd_strobe = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    @(negedge clk);
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({name, "_finished"}, int'(busy), 0);
  endtask

  task automatic push(input string name, input int dur, input int low, input int kind,
                      input int val);
    exp_t e;
    e.name = name;
    e.dur  = dur;
    e.low  = low;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end by 1000000 ns expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    cmd        = 2'b00;
    cmd_strobe = 1'b0;
    tx_bit     = 1'b0;
    #23;
    check("rst_pad_t", int'(pad_t), 1);
    check("rst_pad_o", int'(pad_o), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rx_bit", int'(rx_bit), 0);
    check("rst_presence", int'(presence), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Reset/presence with a device answering 510..700 us; sampled at 550 us.
    dev_lo = 1020;
    dev_hi = 1400;
    push("rst_dev", 960 * CPU, 480 * CPU, 1, 1);
    issue(CMD_RESET, 1'b0);
    wait_idle("rst_dev", 2100);
    dev_lo = 0;
    dev_hi = 0;

    // Write 0 and write 1.
    push("wr0", 70 * CPU, 60 * CPU, 0, 0);
    issue(CMD_WRITE, 1'b0);
    wait_idle("wr0", 200);

    // Write 1 with a reset-command strobe at cycle 50 that must be ignored.
    push("wr1", 70 * CPU, 6 * CPU, 0, 0);
    issue(CMD_WRITE, 1'b1);
    repeat (49) @(posedge clk);
    @(negedge clk);
    cmd        = CMD_RESET;
    cmd_strobe = 1'b1;
    @(posedge clk);
    #1;
    cmd_strobe = 1'b0;
    wait_idle("wr1", 200);

    // Read with the device holding the line low through cycle 40.
    dev_lo = 0;
    dev_hi = 41;
    push("rd0", 70 * CPU, 6 * CPU, 2, 0);
    issue(CMD_READ, 1'b0);
    wait_idle("rd0", 200);
    dev_lo = 0;
    dev_hi = 0;
    check("presence_holds", int'(presence), 1);

    // Read with the line released.
    push("rd1", 70 * CPU, 6 * CPU, 2, 1);
    issue(CMD_READ, 1'b0);
    wait_idle("rd1", 200);

    // Reserved command in IDLE is ignored.
    @(negedge clk);
    cmd        = 2'b11;
    cmd_strobe = 1'b1;
    @(negedge clk);
    cmd_strobe = 1'b0;
    repeat (5) @(negedge clk);
    check("rsvd_busy", int'(busy), 0);
    check("rsvd_pad_t", int'(pad_t), 1);

    // Reset/presence with no device.
    push("rst_nodev", 960 * CPU, 480 * CPU, 1, 0);
    issue(CMD_RESET, 1'b0);
    wait_idle("rst_nodev", 2100);
    check("rx_bit_holds", int'(rx_bit), 1);

    // Reset asserted mid-cycle at cycle 30 of a write 0: abandoned, no done.
    issue(CMD_WRITE, 1'b0);
    repeat (30) @(posedge clk);
    #3;
    check("midrst_pad_t_before", int'(pad_t), 0);
    reset = 1'b1;
    #1;
    check("midrst_pad_t", int'(pad_t), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_rx_bit", int'(rx_bit), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check("midrst_idle_pad_t", int'(pad_t), 1);

    // A subsequent read completes normally.
    push("rd_after_rst", 70 * CPU, 6 * CPU, 2, 1);
    issue(CMD_READ, 1'b0);
    wait_idle("rd_after_rst", 200);

    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
